id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and operand-delivery stage directly upstream of the ALU.
//  Captures decoded instruction fields, derives the 4-bit ALU control code, and forwards
//  EX/MEM and MEM/WB results into the ALU operands. Handles stall, flush and load-use detection.
// PARAMETERS
//  XLEN  32  datapath width (ALU operands, PC, immediates)
//  RADDR  5  register-address width
// PORTS
//  clk                    in   1      clock
//  rst_n                  in   1      synchronous reset, active-low
//  stall_i / flush_i      in   1      hold register / insert bubble
//  id_valid_i             in   1      decode slot holds a real instruction
//  id_pc_i, id_imm_i      in   XLEN   PC, sign-extended immediate
//  id_rs1_data_i/rs2_data in   XLEN   register-file read data
//  id_rs1_i/rs2_i/rd_i    in   RADDR  register addresses
//  id_funct3_i            in   3      instr[14:12]
//  id_funct7b5_i          in   1      instr[30]
//  id_alu_op_i            in   2      00 ld/st, 01 branch, 10 R-type, 11 I-type ALU
//  id_alu_src_i           in   1      1: in2 = imm, 0: in2 = rs2
//  id_reg_write_i, id_mem_read_i, id_mem_write_i, id_branch_i, id_mem_to_reg_i  in 1  ctrl
//  exmem_reg_write_i/rd_i/result_i  in 1/RADDR/XLEN  EX/MEM writeback candidate
//  memwb_reg_write_i/rd_i/result_i  in 1/RADDR/XLEN  MEM/WB writeback candidate
//  alu_in1_o, alu_in2_o   out  XLEN   ALU operands
//  alu_control_o          out  4      ALU opcode
//  ex_store_data_o        out  XLEN   forwarded rs2 for stores
//  ex_pc_o, ex_imm_o      out  XLEN   registered PC / immediate (branch target)
//  ex_valid_o, ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o,
//  ex_mem_to_reg_o        out  1/RADDR  registered control
//  load_use_hazard_o      out  1      combinational: stall IF/ID, flush this stage
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): every register 0. Hence ex_valid_o=0, all ctrl 0,
//    alu_control_o=4'b0000, operands 0 (in absence of forwarding).
//  - Latency: 1 cycle ID->EX. Priority per edge: reset > flush > stall > load.
//  - flush_i: ex_valid and reg_write/mem_read/mem_write/branch/mem_to_reg cleared, data regs 0.
//  - stall_i: all registers hold. Forwarding muxes stay live, so held operands pick up new results.
//  - ALU control, decoded at load:
//    alu_op 00 -> 0010 ADD.
//    alu_op 01 -> 0110 SUB.
//    alu_op 10 -> by funct3: 000 -> ADD, or SUB if funct7b5; 111 AND 0000; 110 OR 0001.
//    alu_op 11 -> same decode, but funct7b5 ignored (ADDI never SUB).
//    Unsupported funct3 -> 4'b1111; the ALU then yields 0, zero=0.
//  - Forwarding (combinational, per operand, from registered rs1/rs2):
//    Use EX/MEM if exmem_reg_write & exmem_rd!=0 & rd==rs.
//    Otherwise MEM/WB under the same rule. Otherwise the registered data.
//    EX/MEM wins when both match. x0 is never forwarded.
//  - Operand outputs: alu_in1_o = fwd rs1; alu_in2_o = alu_src ? imm : fwd rs2;
//    ex_store_data_o = fwd rs2 always.
//  - load_use_hazard_o = ex_valid & ex_mem_read & ex_rd!=0 & id_valid &
//    (ex_rd==id_rs1 | ex_rd==id_rs2).
//    The stall of IF/ID and the flush of this stage are applied externally.
//  - When ex_valid_o=0, outputs are don't-care except ctrl, which must be 0.
//  - Reset mid-stall or mid-flush: reset wins; next load is clean.
// STRUCTURE
//  - riscv_pkg holds:
//    alu_ctrl_e (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_NOP=1111);
//    alu_op_e (LDST, BRANCH, RTYPE, ITYPE);
//    ex_ctrl_t struct bundling the five control bits.
//  - Sub-module alu_control_dec: combinational {alu_op, funct3, funct7b5} -> alu_ctrl_e.
//    Shared with any future decode users.
//  - Forwarding muxes and pipeline register are inline.
// TESTING
//  - Reset: rst_n=0 for 2 clk -> ex_valid_o=0, alu_control_o=0000, all ctrl outputs 0.
//  - Decode: R-type funct3=000, funct7b5=1 -> 0110.
//    ITYPE, same fields -> 0010.
//    funct3=111 -> 0000; 110 -> 0001; 100 -> 1111.
//  - Forward priority: rs1=5; EX/MEM rd=5 res=0xAAAA; MEM/WB rd=5 res=0xBBBB
//    -> alu_in1_o=0xAAAA. With exmem_reg_write=0 -> 0xBBBB. rd=0 -> regfile value.
//  - Load-use: EX holds lw x7 (mem_read=1); ID has add rs2=7 -> load_use_hazard_o=1.
//    Apply flush next edge -> ex_valid_o=0, ctrl 0.
//  - Stall: load addi imm=0x10, then stall_i=1 for 3 cycles with changing ID inputs
//    -> outputs unchanged. Forward update during the stall is visible on alu_in1_o.
//  - Flush+stall same edge -> bubble. alu_src=1, imm=0xFFFF_FFFC -> alu_in2_o=0xFFFF_FFFC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared types for the decode/execute boundary: the 4-bit ALU control
//   codes, the 2-bit main-decoder ALU operation class, the bundle of
//   EX-stage control bits, and the funct3 values the ALU decode recognises.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_NOP = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    LDST   = 2'b00,
    BRANCH = 2'b01,
    RTYPE  = 2'b10,
    ITYPE  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic mem_to_reg;
  } ex_ctrl_t;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_control_dec.sv
// alu_control_dec
//   Combinational ALU control decoder.
//   Ports:
//     i_alu_op    in  2  operation class from the main decoder
//     i_funct3    in  3  instr[14:12]
//     i_funct7b5  in  1  instr[30]
//     o_alu_ctrl  out 4  ALU control code (alu_ctrl_e)
module alu_control_dec
  import riscv_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output alu_ctrl_e  o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_NOP;
    case (i_alu_op)
      LDST:   o_alu_ctrl = ALU_ADD;
      BRANCH: o_alu_ctrl = ALU_SUB;
      default: begin
        // R-type and I-type share the funct3 decode; only R-type can select
        // SUB through instr[30], since ADDI carries immediate bits there.
        case (i_funct3)
          F3_ADD_SUB: o_alu_ctrl = (i_alu_op == RTYPE && i_funct7b5) ? ALU_SUB : ALU_ADD;
          F3_AND:     o_alu_ctrl = ALU_AND;
          F3_OR:      o_alu_ctrl = ALU_OR;
          default:    o_alu_ctrl = ALU_NOP;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register plus operand delivery for the ALU.
//   Ports:
//     clk, rst_n                    clock, synchronous active-low reset
//     stall_i, flush_i              hold the register / insert a bubble
//     id_*                          decoded fields and control from ID
//     exmem_*, memwb_*              writeback candidates used for forwarding
//     alu_in1_o, alu_in2_o          forwarded ALU operands
//     alu_control_o                 registered ALU control code
//     ex_store_data_o               forwarded rs2 for stores
//     ex_pc_o, ex_imm_o             registered PC / immediate
//     ex_valid_o, ex_rd_o, ex_*_o   registered valid, destination and control
//     load_use_hazard_o             load in EX feeds the instruction in ID
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [RADDR-1:0] id_rs1_i,
  input  logic [RADDR-1:0] id_rs2_i,
  input  logic [RADDR-1:0] id_rd_i,
  input  logic [2:0]       id_funct3_i,
  input  logic             id_funct7b5_i,
  input  logic [1:0]       id_alu_op_i,
  input  logic             id_alu_src_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             id_mem_write_i,
  input  logic             id_branch_i,
  input  logic             id_mem_to_reg_i,
  input  logic             exmem_reg_write_i,
  input  logic [RADDR-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]  exmem_result_i,
  input  logic             memwb_reg_write_i,
  input  logic [RADDR-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]  memwb_result_i,
  output logic [XLEN-1:0]  alu_in1_o,
  output logic [XLEN-1:0]  alu_in2_o,
  output logic [3:0]       alu_control_o,
  output logic [XLEN-1:0]  ex_store_data_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic             ex_valid_o,
  output logic [RADDR-1:0] ex_rd_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             ex_branch_o,
  output logic             ex_mem_to_reg_o,
  output logic             load_use_hazard_o
);

  alu_ctrl_e        w_alu_ctrl;
  logic [XLEN-1:0]  w_fwd_rs1;
  logic [XLEN-1:0]  w_fwd_rs2;

  logic             r_valid;
  ex_ctrl_t         r_ctrl;
  alu_ctrl_e        r_alu_ctrl;
  logic             r_alu_src;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_imm;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [RADDR-1:0] r_rs1;
  logic [RADDR-1:0] r_rs2;
  logic [RADDR-1:0] r_rd;

  alu_control_dec u_alu_control_dec (
    .i_alu_op   (id_alu_op_i),
    .i_funct3   (id_funct3_i),
    .i_funct7b5 (id_funct7b5_i),
    .o_alu_ctrl (w_alu_ctrl)
  );

  // A flush clears exactly what reset clears, so both share one branch;
  // reset still dominates because it is the same outcome.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_alu_ctrl <= ALU_AND;
      r_alu_src  <= 1'b0;
      r_pc       <= '0;
      r_imm      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (!stall_i) begin
      r_valid    <= id_valid_i;
      r_ctrl     <= '{reg_write:  id_reg_write_i,
                      mem_read:   id_mem_read_i,
                      mem_write:  id_mem_write_i,
                      branch:     id_branch_i,
                      mem_to_reg: id_mem_to_reg_i};
      r_alu_ctrl <= w_alu_ctrl;
      r_alu_src  <= id_alu_src_i;
      r_pc       <= id_pc_i;
      r_imm      <= id_imm_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
    end
  end

  // Forwarding works off the registered source addresses, so an operand held
  // by a stall still picks up results that arrive while it waits. The nearer
  // EX/MEM result is checked first; x0 is never a forwarding target.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (exmem_reg_write_i && exmem_rd_i != '0 && exmem_rd_i == r_rs1)
      w_fwd_rs1 = exmem_result_i;
    else if (memwb_reg_write_i && memwb_rd_i != '0 && memwb_rd_i == r_rs1)
      w_fwd_rs1 = memwb_result_i;
  end

  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (exmem_reg_write_i && exmem_rd_i != '0 && exmem_rd_i == r_rs2)
      w_fwd_rs2 = exmem_result_i;
    else if (memwb_reg_write_i && memwb_rd_i != '0 && memwb_rd_i == r_rs2)
      w_fwd_rs2 = memwb_result_i;
  end

  assign alu_in1_o       = w_fwd_rs1;
  assign alu_in2_o       = r_alu_src ? r_imm : w_fwd_rs2;
  assign ex_store_data_o = w_fwd_rs2;
  assign alu_control_o   = r_alu_ctrl;
  assign ex_pc_o         = r_pc;
  assign ex_imm_o        = r_imm;
  assign ex_valid_o      = r_valid;
  assign ex_rd_o         = r_rd;
  assign ex_reg_write_o  = r_ctrl.reg_write;
  assign ex_mem_read_o   = r_ctrl.mem_read;
  assign ex_mem_write_o  = r_ctrl.mem_write;
  assign ex_branch_o     = r_ctrl.branch;
  assign ex_mem_to_reg_o = r_ctrl.mem_to_reg;

  // The loaded value is not available until MEM, so the consumer in ID must
  // wait one cycle; the caller stalls IF/ID and flushes this stage.
  assign load_use_hazard_o = r_valid && r_ctrl.mem_read && r_rd != '0 && id_valid_i &&
                             (r_rd == id_rs1_i || r_rd == id_rs2_i);

endmodule
